// File: rtl/de_scoreboard_if.sv
// de_scoreboard_if: DE-side issue, retire and squash signals for the hazard scoreboard
interface de_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int REGBITS = 5,
  parameter int NWB = 2
);
  logic issue_valid, use_rs1, use_rs2, wr_reg, flush, kill_valid;
  logic [REGBITS-1:0] rs1, rs2, rd, kill_regno;
  logic [NWB-1:0] wb_valid;
  logic [NWB*REGBITS-1:0] wb_regno;
  logic stall, issue_fire, err;
  logic [NREGS-1:0] busy;
  modport master (
    output issue_valid, use_rs1, use_rs2, rs1, rs2, wr_reg, rd, flush,
           wb_valid, wb_regno, kill_valid, kill_regno,
    input  stall, issue_fire, busy, err
  );
  modport slave (
    input  issue_valid, use_rs1, use_rs2, rs1, rs2, wr_reg, rd, flush,
           wb_valid, wb_regno, kill_valid, kill_regno,
    output stall, issue_fire, busy, err
  );
endinterface

// File: rtl/de_scoreboard.sv
// de_scoreboard: per-register pending-write counters producing DE stall/issue-fire
module de_scoreboard #(
  parameter int NREGS = 32,
  parameter int REGBITS = 5,
  parameter int CNTBITS = 3,
  parameter int NWB = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit WB_BYPASS = 1'b0
) (
  input logic clk,
  input logic reset,
  de_scoreboard_if.slave sb
);
  logic [CNTBITS-1:0] cnt [NREGS];
  logic [CNTBITS-1:0] nxt [NREGS];
  logic [CNTBITS+1:0] dec [NREGS];
  logic [NREGS-1:0] nz, uf;
  logic hazard, sat;
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = (CNTBITS+2)'(sb.kill_valid && sb.kill_regno == REGBITS'(r));
      for (int k = 0; k < NWB; k++)
        dec[r] = dec[r] + (CNTBITS+2)'(sb.wb_valid[k] && sb.wb_regno[k*REGBITS +: REGBITS] == REGBITS'(r));
      if (ZERO_REG && r == 0) dec[r] = '0;
      nz[r] = !(ZERO_REG && r == 0) && (WB_BYPASS ? {2'b00, cnt[r]} > dec[r] : cnt[r] != '0);
    end
  end
  assign hazard = (sb.use_rs1 && int'(sb.rs1) < NREGS && nz[sb.rs1]) ||
                  (sb.use_rs2 && int'(sb.rs2) < NREGS && nz[sb.rs2]);
  // saturation looks at the registered count only; same-cycle retires do not relieve it
  assign sat = sb.wr_reg && int'(sb.rd) < NREGS && cnt[sb.rd] == '1;
  assign sb.stall = reset || sb.flush || (sb.issue_valid && (hazard || sat));
  assign sb.issue_fire = sb.issue_valid && !sb.stall;
  always_comb begin
    logic [CNTBITS+1:0] t;
    t = '0;
    for (int r = 0; r < NREGS; r++) begin
      t = {2'b00, cnt[r]} + (CNTBITS+2)'(sb.issue_fire && sb.wr_reg && sb.rd == REGBITS'(r) && !(ZERO_REG && r == 0)) - dec[r];
      uf[r] = t[CNTBITS+1];
      nxt[r] = uf[r] ? '0 : t[CNTBITS-1:0];
    end
  end
  for (genvar g = 0; g < NREGS; g++) begin : g_busy
    assign sb.busy[g] = cnt[g] != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      sb.err <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= nxt[r];
      if (|uf) sb.err <= 1'b1;
    end
  end
endmodule
